// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with majority vote, parity/framing/overrun flags and a valid/ready holding register
module uart_rx_cfg #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    P_LAST = 4'(STOP_BITS - 1);
  if (DIV < 1 || OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_rx_cfg: illegal parameter combination");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rxs, rxs_q;
  logic [CW-1:0]          div_q;
  logic [SW-1:0]          smp_q;
  logic [3:0]             bit_q;
  logic                   s0_q, s1_q;
  logic [DATA_BITS-1:0]   sh_q;
  logic                   par_q, frm_q;
  logic                   tick, dec, bit_end, maj, exp_par, commit, accept;
  assign rxs     = sync_q[1];
  assign busy_o  = state_q != IDLE;
  assign tick    = busy_o && div_q == DIV_LAST;
  assign dec     = tick && smp_q == S_C;
  assign bit_end = tick && smp_q == S_LAST;
  // third vote is the live sample at the decision point
  assign maj     = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign exp_par = PARITY == 1 ? ~^sh_q : ^sh_q;
  assign accept  = valid_o && ready_i;
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:  state_d = (rxs_q && !rxs) ? START : IDLE;
      START: state_d = (dec && maj) ? IDLE : bit_end ? DATA : START;
      DATA:  state_d = (bit_end && bit_q == D_LAST) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:   state_d = bit_end ? STOP : PAR;
      STOP: begin
        commit  = dec && bit_q == P_LAST;
        state_d = commit ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
      rxs_q  <= 1'b1;
      div_q  <= '0;
      smp_q  <= '0;
      bit_q  <= '0;
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      frm_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      rxs_q  <= rxs;
      div_q  <= (!busy_o || tick) ? '0 : div_q + 1'b1;
      smp_q  <= !busy_o ? '0 : !tick ? smp_q : smp_q == S_LAST ? '0 : smp_q + 1'b1;
      bit_q  <= state_d != state_q ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
      if (tick && smp_q == S_A) s0_q <= rxs;
      if (tick && smp_q == S_B) s1_q <= rxs;
      if (dec && state_q == DATA) sh_q <= {maj, sh_q[DATA_BITS-1:1]};
      par_q <= !busy_o ? 1'b0 : (dec && state_q == PAR) ? maj != exp_par : par_q;
      frm_q <= !busy_o ? 1'b0 : (dec && state_q == STOP && !maj) ? 1'b1 : frm_q;
    end
  end
  // a commit coinciding with an accept replaces the held word without overrun
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= commit && valid_o && !ready_i;
      if (commit && (!valid_o || ready_i)) begin
        data_o       <= sh_q;
        parity_err_o <= par_q;
        frame_err_o  <= frm_q | !maj;
        valid_o      <= 1'b1;
      end else if (accept) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench over 8N1, 8E1 and 7O2 receivers at 16 clocks per bit
module tb_uart_rx_cfg;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rx = 3'b111;
  logic [2:0] rdy = 3'b000;
  logic [7:0] d_n, d_e;
  logic [6:0] d_o;
  logic [2:0] vld, pe, fe, ovr, bsy;
  int checks = 0;
  int failures = 0;
  int xfers [3] = '{0, 0, 0};
  int ovrs [3] = '{0, 0, 0};
  logic [12:0] q [$];
  logic [12:0] obs_m, exp_m;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk_i(clk), .reset_i(reset), .rx_i(rx[0]), .ready_i(rdy[0]), .data_o(d_n), .valid_o(vld[0]),
    .parity_err_o(pe[0]), .frame_err_o(fe[0]), .overrun_o(ovr[0]), .busy_o(bsy[0]));
  uart_rx_cfg #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
    .clk_i(clk), .reset_i(reset), .rx_i(rx[1]), .ready_i(rdy[1]), .data_o(d_e), .valid_o(vld[1]),
    .parity_err_o(pe[1]), .frame_err_o(fe[1]), .overrun_o(ovr[1]), .busy_o(bsy[1]));
  uart_rx_cfg #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_o (
    .clk_i(clk), .reset_i(reset), .rx_i(rx[2]), .ready_i(rdy[2]), .data_o(d_o), .valid_o(vld[2]),
    .parity_err_o(pe[2]), .frame_err_o(fe[2]), .overrun_o(ovr[2]), .busy_o(bsy[2]));

  // scoreboard entry: {instance, parity_err, frame_err, 9-bit data}
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (ovr[i]) ovrs[i]++;
        if (vld[i] && rdy[i]) begin
          obs_m = i == 0 ? {2'd0, pe[0], fe[0], 1'b0, d_n} :
                  i == 1 ? {2'd1, pe[1], fe[1], 1'b0, d_e} : {2'd2, pe[2], fe[2], 2'b0, d_o};
          xfers[i]++;
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL rx_word: got %h with nothing expected", obs_m);
          end else begin
            exp_m = q.pop_front();
            if (obs_m !== exp_m) begin
              failures++;
              $display("FAIL rx_word: got %h required %h", obs_m, exp_m);
            end
          end
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int sel, input logic b);
    rx[sel] = b;
    wait_cycles(16);
  endtask

  task automatic send_frame(input int sel, input int nd, input logic [8:0] d, input int pmode,
                            input logic pflip, input int nstop, input logic [1:0] stops);
    logic p;
    p = 1'b0;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nd; i++) begin
      drive_bit(sel, d[i]);
      p = p ^ d[i];
    end
    if (pmode != 0) drive_bit(sel, (pmode == 1 ? ~p : p) ^ pflip);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stops[i]);
  endtask

  task automatic test_reset;
    wait_cycles(3);
    checks++;
    if ({d_n, d_e, d_o, vld, pe, fe, ovr, bsy} !== '0) begin
      failures++;
      $display("FAIL reset_state: got %h required 0", {d_n, d_e, d_o, vld, pe, fe, ovr, bsy});
    end
    reset = 1'b0;
    wait_cycles(4);
    checks++;
    if ({vld, bsy} !== '0) begin
      failures++;
      $display("FAIL post_reset_idle: valid/busy %b required 0", {vld, bsy});
    end
  endtask

  task automatic test_8n1;
    int x0;
    logic [7:0] d;
    x0 = xfers[0];
    d = 8'hA5;
    rdy[0] = 1'b1;
    q.push_back({2'd0, 1'b0, 1'b0, 9'h0A5});
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b0) begin
      failures++;
      $display("FAIL start_latency_early: busy=%b required 0", bsy[0]);
    end
    @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: busy=%b required 1", bsy[0]);
    end
    repeat (13) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) drive_bit(0, d[i]);
    drive_bit(0, 1'b1);
    wait_cycles(5);
    checks++;
    if (xfers[0] != x0 + 1 || q.size() != 0 || vld[0] !== 1'b0) begin
      failures++;
      $display("FAIL nominal_8n1: transfers=%0d pending=%0d valid=%b required 1/0/0", xfers[0] - x0, q.size(), vld[0]);
    end
  endtask

  task automatic test_false_start;
    int x0;
    logic seen;
    x0 = xfers[0];
    seen = 1'b0;
    rx[0] = 1'b0;
    wait_cycles(4);
    rx[0] = 1'b1;
    repeat (30) begin
      @(negedge clk);
      seen = seen | bsy[0];
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL false_start_busy: busy seen=%b required 1", seen);
    end
    checks++;
    if (bsy[0] !== 1'b0 || xfers[0] != x0 || vld[0] !== 1'b0) begin
      failures++;
      $display("FAIL false_start_drop: busy=%b transfers=%0d valid=%b required 0/0/0", bsy[0], xfers[0] - x0, vld[0]);
    end
    wait_cycles(1);
  endtask

  task automatic test_parity;
    int x0;
    x0 = xfers[1];
    rdy[1] = 1'b1;
    q.push_back({2'd1, 1'b1, 1'b0, 9'h003});
    send_frame(1, 8, 9'h003, 2, 1'b1, 1, 2'b11);
    q.push_back({2'd1, 1'b0, 1'b0, 9'h003});
    send_frame(1, 8, 9'h003, 2, 1'b0, 1, 2'b11);
    wait_cycles(5);
    checks++;
    if (xfers[1] != x0 + 2 || q.size() != 0) begin
      failures++;
      $display("FAIL parity_8e1: transfers=%0d pending=%0d required 2/0", xfers[1] - x0, q.size());
    end
  endtask

  task automatic test_overrun;
    int x0, o0;
    o0 = ovrs[0];
    rdy[0] = 1'b0;
    q.push_back({2'd0, 1'b0, 1'b0, 9'h011});
    send_frame(0, 8, 9'h011, 0, 1'b0, 1, 2'b11);
    send_frame(0, 8, 9'h022, 0, 1'b0, 1, 2'b11);
    wait_cycles(5);
    checks++;
    if (ovrs[0] != o0 + 1) begin
      failures++;
      $display("FAIL overrun_pulse: pulses=%0d required 1", ovrs[0] - o0);
    end
    checks++;
    if (vld[0] !== 1'b1 || d_n !== 8'h11) begin
      failures++;
      $display("FAIL overrun_hold: valid=%b data=%h required 1/11", vld[0], d_n);
    end
    x0 = xfers[0];
    rdy[0] = 1'b1;
    wait_cycles(3);
    checks++;
    if (xfers[0] != x0 + 1 || vld[0] !== 1'b0 || q.size() != 0) begin
      failures++;
      $display("FAIL overrun_drain: transfers=%0d valid=%b pending=%0d required 1/0/0", xfers[0] - x0, vld[0], q.size());
    end
  endtask

  task automatic test_back_to_back;
    int o0, x0;
    logic [8:0] vals [3] = '{9'h0C3, 9'h07E, 9'h100};
    o0 = ovrs[0];
    x0 = xfers[0];
    rdy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q.push_back({2'd0, 1'b0, 1'b0, 1'b0, vals[i][7:0]});
      send_frame(0, 8, vals[i], 0, 1'b0, 1, 2'b11);
    end
    wait_cycles(5);
    checks++;
    if (ovrs[0] != o0 || xfers[0] != x0 + 3 || q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back: overruns=%0d transfers=%0d pending=%0d required 0/3/0", ovrs[0] - o0, xfers[0] - x0, q.size());
    end
  endtask

  task automatic test_7o2;
    int x0;
    x0 = xfers[2];
    rdy[2] = 1'b1;
    q.push_back({2'd2, 1'b0, 1'b1, 9'h055});
    send_frame(2, 7, 9'h055, 1, 1'b0, 2, 2'b10);
    rx[2] = 1'b1;
    wait_cycles(20);
    q.push_back({2'd2, 1'b0, 1'b0, 9'h02A});
    send_frame(2, 7, 9'h02A, 1, 1'b0, 2, 2'b11);
    wait_cycles(5);
    checks++;
    if (xfers[2] != x0 + 2 || q.size() != 0) begin
      failures++;
      $display("FAIL frame_7o2: transfers=%0d pending=%0d required 2/0", xfers[2] - x0, q.size());
    end
  endtask

  task automatic test_reset_break;
    int x0;
    logic [7:0] d;
    d = 8'h3C;
    rdy[0] = 1'b0;
    send_frame(0, 8, 9'h05A, 0, 1'b0, 1, 2'b11);
    wait_cycles(3);
    checks++;
    if (vld[0] !== 1'b1 || d_n !== 8'h5A) begin
      failures++;
      $display("FAIL held_before_reset: valid=%b data=%h required 1/5a", vld[0], d_n);
    end
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    rx[0] = d[4];
    wait_cycles(5);
    reset = 1'b1;
    #1;
    checks++;
    if ({d_n, vld[0], pe[0], fe[0], ovr[0], bsy[0]} !== '0) begin
      failures++;
      $display("FAIL reset_mid_frame: got %h required 0", {d_n, vld[0], pe[0], fe[0], ovr[0], bsy[0]});
    end
    rx[0] = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(3);
    x0 = xfers[0];
    rdy[0] = 1'b1;
    q.push_back({2'd0, 1'b0, 1'b1, 9'h000});
    rx[0] = 1'b0;
    wait_cycles(15 * 16);
    checks++;
    if (bsy[0] !== 1'b0) begin
      failures++;
      $display("FAIL break_idle: busy=%b required 0", bsy[0]);
    end
    rx[0] = 1'b1;
    wait_cycles(20);
    checks++;
    if (xfers[0] != x0 + 1 || q.size() != 0) begin
      failures++;
      $display("FAIL break_word: transfers=%0d pending=%0d required 1/0", xfers[0] - x0, q.size());
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_false_start;
    test_parity;
    test_overrun;
    test_back_to_back;
    test_7o2;
    test_reset_break;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
